// File: rtl/ram_pkg.sv
// Shared types and constants for the ram_sp_clr storage primitive and its clear sequencer.
package ram_pkg;

    typedef enum logic {
        RAM_CLEAR,
        RAM_READY
    } ram_state_e;

    // Replicated to DATA_W at the point of use to form the clear word.
    localparam logic ZERO_FILL_BIT = 1'b0;

endpackage

// File: rtl/ram_clr_seq.sv
// Clear sequencer for ram_sp_clr: walks every address writing zero after reset or clr_req,
// then holds READY until the next clear request.
module ram_clr_seq #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready
);
    import ram_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_state_e        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            RAM_CLEAR: begin
                // A repeated request simply restarts the walk from address 0.
                if (clr_req) begin
                    ptr_d = '0;
                end else if (ptr_q == LAST_ADDR) begin
                    state_d = RAM_READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            RAM_READY: begin
                if (clr_req) begin
                    state_d = RAM_CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = RAM_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RAM_CLEAR;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == RAM_READY);
        end
    end

    assign clr_we   = (state_q == RAM_CLEAR);
    assign clr_addr = ptr_q;
    assign ready    = ready_q;

endmodule

// File: rtl/ram_sp_clr.sv
// Simple dual-port RAM (one write, one registered read port) with a built-in zeroing sequencer.
// Define RAM_BYPASS_EN for write-first same-address behaviour; otherwise reads are read-first.
module ram_sp_clr #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic              ready
);
    import ram_pkg::*;

    localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{ZERO_FILL_BIT}};
    // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              rd_in_range;
    logic              rd_fire;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_data;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              rd_err_q;

    ram_clr_seq #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .ready    (ready)
    );

    assign wr_ok       = ready && wr_en && ({1'b0, wr_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_X);
    assign rd_fire     = ready && rd_en;

    // The sequencer owns the write port while clearing; user writes are dropped then.
    always_comb begin
        arr_we   = 1'b0;
        arr_addr = clr_addr;
        arr_data = ZERO_WORD;
        if (!ready) begin
            arr_we = clr_we;
        end else if (wr_ok) begin
            arr_we   = 1'b1;
            arr_addr = wr_addr;
            arr_data = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            mem[arr_addr] <= arr_data;
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifdef RAM_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr)) begin
            rd_word = wr_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= ZERO_WORD;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            rd_err_q   <= 1'b0;
            if (rd_fire) begin
                if (rd_in_range) begin
                    rd_data_q <= rd_word;
                end else begin
                    rd_data_q <= ZERO_WORD;
                    rd_err_q  <= 1'b1;
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule
